systolic_ctrl: RTL and testbench

- Sequencer in front of the N×N weight-stationary systolic array; the array is shared with nothing else.
- Loads one weight tile by shifting N beats through the rows, then pulses the weight latch.
- Streams activation vectors into the array with a diagonal skew (row i delayed i+1 advances).
- Deskews the bottom-edge column sums through per-column FIFOs and emits whole result vectors on a valid/ready stream.

---
 rtl/systolic_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_systolic_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_ctrl
//
// Sequencer for an N x N weight-stationary systolic array. A job loads one
// weight tile (N beats shifted through the rows), pulses the weight latch,
// streams num_vectors activation vectors into the array with a diagonal
// skew, flushes the skew with N bubble advances, and waits until every
// result vector has been read out before pulsing done.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, num_vectors       job start pulse (IDLE only) and vector count
//   busy, done               not-IDLE flag, one-cycle end-of-job pulse
//   w_valid/w_ready/w_data   weight beats, lane i = row i
//   a_valid/a_ready/a_data   activation vectors, lane i = row i
//   r_valid/r_ready/r_data   result vectors, lane j = column j
//   arr_*                    connection to the array (row inputs, column
//                            outputs, weight load/latch controls)
// ---------------------------------------------------------------------------
module systolic_ctrl #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_WIDTH-1:0]    num_vectors,
    output logic                    busy,
    output logic                    done,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [N*DATA_WIDTH-1:0] w_data,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [N*DATA_WIDTH-1:0] a_data,
    output logic                    r_valid,
    input  logic                    r_ready,
    output logic [N*ACC_WIDTH-1:0]  r_data,
    output logic [N-1:0]            arr_load_weight,
    output logic                    arr_weight_latch_en,
    output logic [N-1:0]            arr_valid,
    input  logic [N-1:0]            arr_ready,
    output logic [N*DATA_WIDTH-1:0] arr_x,
    output logic [N*ACC_WIDTH-1:0]  arr_y,
    input  logic [N-1:0]            arr_valid_y,
    output logic [N-1:0]            arr_ready_y,
    input  logic [N*ACC_WIDTH-1:0]  arr_y_out
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LATCH,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state_reg;
    logic [CNT_WIDTH-1:0] num_reg;
    logic [CNT_WIDTH-1:0] beat_reg;
    logic [CNT_WIDTH-1:0] in_cnt_reg;
    logic [CNT_WIDTH-1:0] out_cnt_reg;
    logic [CNT_WIDTH-1:0] drain_reg;

    logic                    adv;
    logic                    accept_w;
    logic                    accept_a;
    logic                    shift;
    logic                    pop_all;
    logic [N-1:0]            pipe_v;
    logic [N*DATA_WIDTH-1:0] pipe_x;
    logic [N-1:0]            not_empty;

    // The whole array moves in lockstep, so one stalled row stalls all rows.
    assign adv      = &arr_ready;
    assign w_ready  = (state_reg == S_LOAD_W) && adv;
    assign accept_w = w_valid && w_ready;
    assign a_ready  = (state_reg == S_STREAM) && adv && (in_cnt_reg < num_reg);
    assign accept_a = a_valid && a_ready;
    // Skew pipes move on every advance while streaming and for the first N
    // advances of the drain (those carry bubbles that flush the diagonal).
    assign shift    = adv && ((state_reg == S_STREAM) ||
                              ((state_reg == S_DRAIN) && (drain_reg < CNT_WIDTH'(N))));

    assign busy                = (state_reg != S_IDLE);
    assign done                = (state_reg == S_DONE);
    assign arr_weight_latch_en = (state_reg == S_LATCH);
    assign arr_y               = '0;

    // ------------------------------------------------------------------
    // Control FSM and job counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            num_reg     <= '0;
            beat_reg    <= '0;
            in_cnt_reg  <= '0;
            out_cnt_reg <= '0;
            drain_reg   <= '0;
        end else begin
            if (pop_all) begin
                out_cnt_reg <= out_cnt_reg + CNT_ONE;
            end
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        num_reg     <= num_vectors;
                        beat_reg    <= '0;
                        in_cnt_reg  <= '0;
                        out_cnt_reg <= '0;
                        drain_reg   <= '0;
                        state_reg   <= S_LOAD_W;
                    end
                end
                S_LOAD_W: begin
                    if (accept_w) begin
                        beat_reg <= beat_reg + CNT_ONE;
                        if (beat_reg == CNT_WIDTH'(N - 1)) begin
                            state_reg <= S_LATCH;
                        end
                    end
                end
                S_LATCH: begin
                    drain_reg <= '0;
                    state_reg <= (num_reg == '0) ? S_DRAIN : S_STREAM;
                end
                S_STREAM: begin
                    if (accept_a) begin
                        in_cnt_reg <= in_cnt_reg + CNT_ONE;
                        if ((in_cnt_reg + CNT_ONE) == num_reg) begin
                            state_reg <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_reg < CNT_WIDTH'(N)) begin
                        if (adv) begin
                            drain_reg <= drain_reg + CNT_ONE;
                        end
                    end else if (out_cnt_reg == num_reg) begin
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Input skew: row gi has gi+1 stages, each carrying {valid, data}.
    // Bubbles still carry a_data; only the valid bit matters to the array.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            logic [gi:0]           v_pipe_reg;
            logic [DATA_WIDTH-1:0] x_pipe_reg [0:gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k <= gi; k++) begin
                        v_pipe_reg[k] <= 1'b0;
                        x_pipe_reg[k] <= '0;
                    end
                end else if (shift) begin
                    v_pipe_reg[0] <= accept_a;
                    x_pipe_reg[0] <= a_data[gi*DATA_WIDTH +: DATA_WIDTH];
                    for (int k = 1; k <= gi; k++) begin
                        v_pipe_reg[k] <= v_pipe_reg[k-1];
                        x_pipe_reg[k] <= x_pipe_reg[k-1];
                    end
                end
            end

            assign pipe_v[gi]                           = v_pipe_reg[gi];
            assign pipe_x[gi*DATA_WIDTH +: DATA_WIDTH]  = x_pipe_reg[gi];
        end
    endgenerate

    // Weight beats bypass the skew: every row shifts the same beat together.
    always_comb begin
        arr_load_weight = '0;
        arr_valid       = '0;
        arr_x           = '0;
        case (state_reg)
            S_LOAD_W: begin
                arr_load_weight = {N{w_valid}};
                arr_valid       = {N{w_valid}};
                arr_x           = w_data;
            end
            S_STREAM, S_DRAIN: begin
                arr_valid = pipe_v;
                arr_x     = pipe_x;
            end
            default: begin
                arr_load_weight = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-column result FIFOs. Columns finish at different cycles because
    // of the skew; a result vector is only complete when every column has
    // a head entry, and all columns pop together.
    // ------------------------------------------------------------------
    assign r_valid = &not_empty;
    assign pop_all = r_valid && r_ready;

    generate
        for (gi = 0; gi < N; gi++) begin : g_col
            logic [ACC_WIDTH-1:0] mem [0:FIFO_DEPTH-1];
            logic [PW-1:0]        wr_ptr_reg;
            logic [PW-1:0]        rd_ptr_reg;
            logic [PW:0]          count_reg;
            logic                 full;
            logic                 push;

            assign full            = (count_reg == (PW+1)'(FIFO_DEPTH));
            assign not_empty[gi]   = (count_reg != '0);
            assign arr_ready_y[gi] = !full;
            assign push            = arr_valid_y[gi] && !full;
            assign r_data[gi*ACC_WIDTH +: ACC_WIDTH] = mem[rd_ptr_reg];

            // Storage is left out of reset; the pointers define validity.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr_reg] <= arr_y_out[gi*ACC_WIDTH +: ACC_WIDTH];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= wr_ptr_reg + PW'(1);
                    end
                    if (pop_all) begin
                        rd_ptr_reg <= rd_ptr_reg + PW'(1);
                    end
                    case ({push, pop_all})
                        2'b10:   count_reg <= count_reg + (PW+1)'(1);
                        2'b01:   count_reg <= count_reg - (PW+1)'(1);
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_systolic_ctrl.sv
// ---------------------------------------------------------------------------
// tb_systolic_ctrl
//
// Drives systolic_ctrl through a sequence of jobs (full-rate, skew pattern,
// row stall, result backpressure, empty job, reset mid-stream, random jobs)
// and compares every output each cycle against a job-level reference model:
// a phase tracker, a per-advance history of accepted vectors (row i shows
// the vector accepted i advances earlier) and per-column result queues.
// ---------------------------------------------------------------------------
module tb_systolic_ctrl;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int CW = 16;
    localparam int FD = 4;

    localparam int M_FULL   = 1;
    localparam int M_FIXED  = 2;
    localparam int M_STALL  = 4;
    localparam int M_BP     = 8;
    localparam int M_RSTMID = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [CW-1:0]   num_vectors;
    logic            busy, done;
    logic            w_valid, w_ready;
    logic [N*DW-1:0] w_data;
    logic            a_valid, a_ready;
    logic [N*DW-1:0] a_data;
    logic            r_valid, r_ready;
    logic [N*AW-1:0] r_data;
    logic [N-1:0]    arr_load_weight;
    logic            arr_weight_latch_en;
    logic [N-1:0]    arr_valid, arr_ready;
    logic [N*DW-1:0] arr_x;
    logic [N*AW-1:0] arr_y;
    logic [N-1:0]    arr_valid_y, arr_ready_y;
    logic [N*AW-1:0] arr_y_out;

    always #5 clk = ~clk;

    systolic_ctrl #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
        .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .arr_load_weight(arr_load_weight), .arr_weight_latch_en(arr_weight_latch_en),
        .arr_valid(arr_valid), .arr_ready(arr_ready), .arr_x(arr_x), .arr_y(arr_y),
        .arr_valid_y(arr_valid_y), .arr_ready_y(arr_ready_y), .arr_y_out(arr_y_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model
    typedef enum {M_IDLE, M_LOAD, M_LATCH, M_STREAM, M_DRAIN, M_DONE} ph_t;
    ph_t ph;
    int  nv, beats, in_cnt, out_cnt, drain_cnt, adv_no;
    bit              acc_v [0:4095];
    logic [N*DW-1:0] acc_d [0:4095];
    logic [AW-1:0]   fq [N][$];

    // Per-job bookkeeping
    int nv_job, push_cnt [N];
    int done_seen, lw_seen, latch_seen, pop_seen, full_seen, stall_left, stall_done;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ph = M_IDLE;
        nv = 0; beats = 0; in_cnt = 0; out_cnt = 0; drain_cnt = 0; adv_no = 0;
        for (int j = 0; j < N; j++) fq[j].delete();
    endtask

    // One clock cycle: check outputs against the model for the inputs
    // currently applied, then clock and advance the model.
    task automatic cyc();
        bit              adv, e_ar, e_rv, acc;
        logic [N-1:0]    e_rdy_y, ev;
        logic [N*DW-1:0] ex, xm;
        logic [N*AW-1:0] e_rd;
        int              k, oc_pre;
        #1;
        adv  = &arr_ready;
        e_ar = (ph == M_STREAM) && adv && (in_cnt < nv);
        ev = '0; ex = '0; xm = '0; e_rd = '0; e_rv = 1'b1;
        case (ph)
            M_LOAD: begin
                ev = {N{w_valid}};
                ex = w_data;
                xm = w_valid ? '1 : '0;
            end
            M_STREAM, M_DRAIN: begin
                for (int i = 0; i < N; i++) begin
                    k = adv_no - i;
                    if (k >= 1 && acc_v[k]) begin
                        ev[i] = 1'b1;
                        ex[i*DW +: DW] = acc_d[k][i*DW +: DW];
                        xm[i*DW +: DW] = '1;
                    end
                end
            end
            default: xm = '1;
        endcase
        for (int j = 0; j < N; j++) begin
            e_rdy_y[j] = (fq[j].size() < FD);
            if (fq[j].size() == 0) e_rv = 1'b0;
            else e_rd[j*AW +: AW] = fq[j][0];
        end

        chk("busy", 128'(busy), 128'(ph != M_IDLE));
        chk("done", 128'(done), 128'(ph == M_DONE));
        chk("w_ready", 128'(w_ready), 128'((ph == M_LOAD) && adv));
        chk("a_ready", 128'(a_ready), 128'(e_ar));
        chk("arr_load_weight", 128'(arr_load_weight), 128'((ph == M_LOAD && w_valid) ? {N{1'b1}} : {N{1'b0}}));
        chk("arr_weight_latch_en", 128'(arr_weight_latch_en), 128'(ph == M_LATCH));
        chk("arr_valid", 128'(arr_valid), 128'(ev));
        chk("arr_x", 128'(arr_x & xm), 128'(ex & xm));
        chk("arr_y", 128'(arr_y), 128'(0));
        chk("arr_ready_y", 128'(arr_ready_y), 128'(e_rdy_y));
        chk("r_valid", 128'(r_valid), 128'(e_rv));
        if (e_rv) chk("r_data", 128'(r_data), 128'(e_rd));

        if (arr_load_weight == {N{1'b1}}) lw_seen++;
        if (arr_weight_latch_en) latch_seen++;
        if (done) done_seen++;
        if (r_valid && r_ready) pop_seen++;
        if (arr_ready_y == '0) full_seen = 1;

        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            oc_pre = out_cnt;
            if (e_rv && r_ready) begin
                for (int j = 0; j < N; j++) void'(fq[j].pop_front());
                out_cnt++;
            end
            for (int j = 0; j < N; j++) begin
                if (arr_valid_y[j] && e_rdy_y[j]) begin
                    fq[j].push_back(arr_y_out[j*AW +: AW]);
                    push_cnt[j]++;
                end
            end
            case (ph)
                M_IDLE: if (start) begin
                    nv = int'(num_vectors);
                    beats = 0; in_cnt = 0; out_cnt = 0; adv_no = 0;
                    for (int i = 0; i < 4096; i++) acc_v[i] = 1'b0;
                    ph = M_LOAD;
                end
                M_LOAD: if (w_valid && adv) begin
                    beats++;
                    if (beats == N) ph = M_LATCH;
                end
                M_LATCH: begin
                    drain_cnt = 0;
                    ph = (nv == 0) ? M_DRAIN : M_STREAM;
                end
                M_STREAM: if (adv && adv_no < 4095) begin
                    adv_no++;
                    acc = e_ar && a_valid;
                    acc_v[adv_no] = acc;
                    acc_d[adv_no] = a_data;
                    if (acc) begin
                        in_cnt++;
                        if (in_cnt == nv) ph = M_DRAIN;
                    end
                end
                M_DRAIN: begin
                    if (drain_cnt < N) begin
                        if (adv && adv_no < 4095) begin
                            adv_no++;
                            acc_v[adv_no] = 1'b0;
                            drain_cnt++;
                        end
                    end else if (oc_pre == nv) begin
                        ph = M_DONE;
                    end
                end
                M_DONE: ph = M_IDLE;
                default: ph = M_IDLE;
            endcase
        end
        #1;
    endtask

    task automatic drive(input int mode, input int c);
        w_valid = (mode & M_FULL) ? 1'b1 : ($urandom_range(0, 3) != 0);
        w_data  = $urandom;
        a_valid = ($urandom_range(0, 3) != 0);
        a_data  = (mode & M_FIXED) ? {8'd4, 8'd3, 8'd2, 8'd1} : $urandom;
        r_ready = ((mode & M_BP) && c < 40) ? 1'b0 : 1'($urandom_range(0, 1));
        for (int i = 0; i < N; i++)
            arr_ready[i] = (mode & M_FULL) ? 1'b1 : ($urandom_range(0, 9) != 0);
        if ((mode & M_STALL) && ph == M_STREAM && in_cnt >= 1 && !stall_done) begin
            stall_left = 5;
            stall_done = 1;
        end
        if (stall_left > 0) begin
            arr_ready[2] = 1'b0;
            stall_left--;
        end
        for (int j = 0; j < N; j++) begin
            arr_valid_y[j] = (push_cnt[j] < nv_job) &&
                             ((mode & M_BP) ? 1'b1 : 1'($urandom_range(0, 1)));
            arr_y_out[j*AW +: AW] = $urandom;
        end
    endtask

    task automatic run_job(input int n, input int mode);
        int c;
        nv_job = n;
        for (int j = 0; j < N; j++) push_cnt[j] = 0;
        done_seen = 0; lw_seen = 0; latch_seen = 0; pop_seen = 0;
        full_seen = 0; stall_left = 0; stall_done = 0;
        drive(mode, 0);
        arr_valid_y = '0;
        start = 1'b1;
        num_vectors = CW'(n);
        cyc();
        start = 1'b0;
        c = 0;
        while (ph != M_IDLE && c < 3000) begin
            drive(mode, c);
            if ((mode & M_RSTMID) && ph == M_STREAM && in_cnt == 1) begin
                rst = 1'b1;
                cyc();
                rst = 1'b0;
                break;
            end
            cyc();
            c++;
        end
        $display("job n=%0d mode=%0d cycles=%0d done=%0d pops=%0d", n, mode, c, done_seen, pop_seen);
        if (!(mode & M_RSTMID)) begin
            chk("job_done_count", 128'(done_seen), 128'(1));
            chk("job_result_count", 128'(pop_seen), 128'(n));
            chk("job_latch_pulses", 128'(latch_seen), 128'(1));
            if (mode & M_FULL) chk("job_load_beats", 128'(lw_seen), 128'(N));
            if (mode & M_BP) chk("fifo_full_seen", 128'(full_seen), 128'(1));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_vectors = '0;
        w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
        r_ready = 1'b0; arr_ready = '1; arr_valid_y = '0; arr_y_out = '0;
        nv_job = 0;
        for (int j = 0; j < N; j++) push_cnt[j] = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        cyc();                                  // reset values
        run_job(3, M_FULL);                     // basic full-rate job
        run_job(1, M_FULL | M_FIXED);           // skew pattern 1,2,3,4
        run_job(5, M_FULL | M_STALL);           // row 2 stall mid-stream
        run_job(6, M_FULL | M_BP);              // result backpressure
        run_job(0, 0);                          // empty job
        run_job(4, M_FULL | M_RSTMID);          // reset mid-stream
        cyc();                                  // outputs back at reset values
        run_job(2, 0);                          // job after reset
        for (int t = 0; t < 6; t++) run_job(int'($urandom_range(0, 7)), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
